// File: rtl/uart_alu_pkg.sv
// Shared opcodes, header length and parser state encoding for the UART ALU responder.
package uart_alu_pkg;

  localparam logic [7:0]  OP_ECHO = 8'hEC;
  localparam logic [7:0]  OP_ADD  = 8'hA0;
  localparam logic [7:0]  OP_MUL  = 8'hB0;
  localparam logic [15:0] HDR_LEN = 16'd4;

  typedef enum logic [2:0] {
    StOpc,
    StRsv,
    StLenLo,
    StLenHi,
    StEcho,
    StOper,
    StDrain,
    StResult
  } state_e;

endpackage

// File: rtl/uart_alu_result_ser.sv
// Loads a 32-bit word and streams it out as 4 little-endian bytes with backpressure.
module uart_alu_result_ser (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        tready_i,
  output logic [7:0]  tdata_o,
  output logic        tvalid_o,
  output logic        last_o
);

  logic [31:0] data_q, data_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        hs;

  assign hs       = valid_q & tready_i;
  assign tdata_o  = data_q[7:0];
  assign tvalid_o = valid_q;
  assign last_o   = hs & (cnt_q == 2'd3);

  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = word_i;
      cnt_d   = 2'd0;
      valid_d = 1'b1;
    end else if (hs) begin
      data_d = {8'h00, data_q[31:8]};
      cnt_d  = cnt_q + 2'd1;
      if (cnt_q == 2'd3) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/uart_alu_responder.sv
// Parses framed UART ALU packets (ECHO/ADD32/MUL32) and streams the response bytes back.
module uart_alu_responder
  import uart_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] remaining_q, remaining_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] acc_q, acc_d;
  logic        first_q, first_d;
  logic [7:0]  echo_data_q, echo_data_d;
  logic        echo_valid_q, echo_valid_d;
  logic        live_q;

  logic        s_hs;
  logic [15:0] len;
  logic [31:0] opnd_full;
  logic [31:0] acc_new;
  logic        ser_load;
  logic [7:0]  ser_data;
  logic        ser_valid;
  logic        ser_last;

  assign s_hs      = s_axis_tvalid & s_axis_tready;
  assign len       = {s_axis_tdata, len_lo_q};
  // Operand bytes enter at the top so the 4th byte completes a little-endian word.
  assign opnd_full = {s_axis_tdata, opnd_q[31:8]};
  assign acc_new   = first_q            ? opnd_full :
                     (opcode_q == OP_MUL) ? acc_q * opnd_full : acc_q + opnd_full;

  assign m_axis_tvalid = echo_valid_q | ser_valid;
  assign m_axis_tdata  = ser_valid ? ser_data : echo_data_q;

  // live_q keeps the input closed until the first cycle after reset is released.
  always_comb begin
    s_axis_tready = 1'b0;
    if (live_q) begin
      unique case (state_q)
        StEcho:   s_axis_tready = (remaining_q != '0) && (!echo_valid_q || m_axis_tready);
        StResult: s_axis_tready = 1'b0;
        default:  s_axis_tready = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    len_lo_d     = len_lo_q;
    remaining_d  = remaining_q;
    byte_idx_d   = byte_idx_q;
    opnd_d       = opnd_q;
    acc_d        = acc_q;
    first_d      = first_q;
    echo_data_d  = echo_data_q;
    echo_valid_d = echo_valid_q;
    ser_load     = 1'b0;

    unique case (state_q)
      StOpc: begin
        if (s_hs) begin
          opcode_d = s_axis_tdata;
          state_d  = StRsv;
        end
      end
      StRsv: begin
        if (s_hs) state_d = StLenLo;
      end
      StLenLo: begin
        if (s_hs) begin
          len_lo_d = s_axis_tdata;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (s_hs) begin
          remaining_d = (len >= HDR_LEN) ? len - HDR_LEN : '0;
          byte_idx_d  = '0;
          opnd_d      = '0;
          first_d     = 1'b1;
          if (len <= HDR_LEN) begin
            state_d = StOpc;
          end else if (opcode_q == OP_ECHO) begin
            state_d = StEcho;
          end else if ((opcode_q == OP_ADD || opcode_q == OP_MUL) &&
                       len >= 16'd8 && len[1:0] == 2'b00) begin
            state_d = StOper;
          end else begin
            state_d = StDrain;
          end
        end
      end
      StEcho: begin
        if (s_hs) begin
          echo_data_d  = s_axis_tdata;
          echo_valid_d = 1'b1;
          remaining_d  = remaining_q - 16'd1;
        end else if (echo_valid_q && m_axis_tready) begin
          echo_valid_d = 1'b0;
          if (remaining_q == '0) state_d = StOpc;
        end
      end
      StOper: begin
        if (s_hs) begin
          remaining_d = remaining_q - 16'd1;
          byte_idx_d  = byte_idx_q + 2'd1;
          opnd_d      = opnd_full;
          if (byte_idx_q == 2'd3) begin
            acc_d   = acc_new;
            first_d = 1'b0;
          end
          if (remaining_q == 16'd1) begin
            ser_load = 1'b1;
            state_d  = StResult;
          end
        end
      end
      StDrain: begin
        if (s_hs) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = StOpc;
        end
      end
      StResult: begin
        if (ser_last) state_d = StOpc;
      end
      default: state_d = StOpc;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StOpc;
      opcode_q     <= '0;
      len_lo_q     <= '0;
      remaining_q  <= '0;
      byte_idx_q   <= '0;
      opnd_q       <= '0;
      acc_q        <= '0;
      first_q      <= 1'b1;
      echo_data_q  <= '0;
      echo_valid_q <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      len_lo_q     <= len_lo_d;
      remaining_q  <= remaining_d;
      byte_idx_q   <= byte_idx_d;
      opnd_q       <= opnd_d;
      acc_q        <= acc_d;
      first_q      <= first_d;
      echo_data_q  <= echo_data_d;
      echo_valid_q <= echo_valid_d;
      live_q       <= 1'b1;
    end
  end

  uart_alu_result_ser u_result_ser (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (ser_load),
    .word_i   (acc_new),
    .tready_i (m_axis_tready),
    .tdata_o  (ser_data),
    .tvalid_o (ser_valid),
    .last_o   (ser_last)
  );

endmodule
